// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external multiplexed address/data bus.
// Used by both the responder and the master-side bus model.
package ext_bus_pkg;

  localparam int unsigned AD_W   = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [5:0] DEF_BASE       = 6'h01;
  localparam logic [7:0] DEF_RESET_WAIT = 8'd3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    RDY,
    HOLD
  } state_t;

endpackage

// File: rtl/ext_bus_resp_mem.sv
// Single-port synchronous byte array with one-cycle read latency.
// Contents are not reset; a read during a write returns the old byte.
module ext_bus_resp_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/ext_bus_responder.sv
// Off-chip target on the MCU multiplexed bus: address latch, window decode,
// programmable wait states and a one-cycle ready pulse per serviced byte.
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter int unsigned                ADDR_W     = 10,
  parameter logic [AD_W-ADDR_W-1:0]     BASE       = (AD_W-ADDR_W)'(DEF_BASE),
  parameter logic [7:0]                 RESET_WAIT = DEF_RESET_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_read,
  input  logic              ext_write,
  input  logic              ae,
  input  logic [AD_W-1:0]   bus_ad,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_oe,
  output logic              ready,
  input  logic              cfg_wait_ld,
  input  logic [7:0]        cfg_wait,
  output logic              err,
  input  logic              err_clr
);

  state_t            state;
  logic [AD_W-1:0]   addr_q;
  logic [7:0]        wait_reg;
  logic [7:0]        wait_q;
  logic [7:0]        cnt;
  logic              is_rd;

  logic              hit;
  logic              one_strobe;
  logic              both_strobes;
  logic              held;
  logic              err_set;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  always_comb begin
    hit          = (addr_q[AD_W-1:ADDR_W] == BASE);
    one_strobe   = ext_read ^ ext_write;
    both_strobes = ext_read & ext_write;
    held         = is_rd ? ext_read : ext_write;
    err_set      = both_strobes && !ae && ((state == IDLE) || (state == ADDR));
    // The write commits on the very edge that moves WAIT -> RDY.
    mem_we       = (state == WAIT) && !is_rd && ext_write && (cnt == wait_q);
  end

  ext_bus_resp_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q[ADDR_W-1:0]),
    .din  (bus_ad[DATA_W-1:0]),
    .dout (mem_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wait_reg <= RESET_WAIT;
      wait_q   <= '0;
      cnt      <= '0;
      is_rd    <= 1'b0;
      rd_data  <= '0;
      rd_oe    <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready <= 1'b0;

      if (cfg_wait_ld) wait_reg <= cfg_wait;

      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          if (ae) begin
            addr_q <= bus_ad;
            state  <= ADDR;
          end
        end

        ADDR: begin
          if (ae) begin
            addr_q <= bus_ad;
          end else if (both_strobes) begin
            state <= IDLE;
          end else if (one_strobe) begin
            if (hit) begin
              state  <= WAIT;
              cnt    <= '0;
              wait_q <= wait_reg;
              is_rd  <= ext_read;
              rd_oe  <= ext_read;
            end else begin
              state <= IDLE;
            end
          end
        end

        WAIT: begin
          if (!held) begin
            state <= IDLE;
            rd_oe <= 1'b0;
          end else begin
            if (is_rd) rd_data <= mem_dout;
            if (cnt == wait_q) begin
              state <= RDY;
              ready <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        RDY: begin
          state <= HOLD;
          rd_oe <= is_rd & ext_read;
        end

        HOLD: begin
          rd_oe <= rd_oe & ext_read;
          if (!ext_read && !ext_write) begin
            rd_oe <= 1'b0;
            if (ae) begin
              addr_q <= bus_ad;
              state  <= ADDR;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ext_bus_responder.md
Name: ext_bus_responder

Overview:
- Off-chip target for the MCU external multiplexed address/data bus.
- Behaviour:
  - latches the address on the address-enable pulse;
  - decodes a window;
  - services one byte read or write from a local byte array after a programmable number of wait states;
  - answers with a one-cycle ready pulse.
- Used as the external memory model on the board/FPGA and as the bus-functional target in MCU system benches.

Parameters:
- ADDR_W, 10, local array address width (2^ADDR_W bytes).
- BASE, 6'h01, required value of bus address bits [15:ADDR_W] for a hit.
- RESET_WAIT, 8'd3, reset value of the internal wait-state register.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ext_read  in  1  master read strobe, held until ready seen
- ext_write  in  1  master write strobe, held until ready seen
- ae  in  1  address enable; bus_ad carries address while high
- bus_ad  in  16  multiplexed bus: address during ae, write data in [7:0] during ext_write
- rd_data  out  8  read data toward master
- rd_oe  out  1  responder drives rd_data (board tristate enable)
- ready  out  1  one-cycle transfer-complete pulse
- cfg_wait_ld  in  1  load wait-state register
- cfg_wait  in  8  wait-state value
- err  out  1  sticky protocol error flag
- err_clr  in  1  clears err

Behaviour:
- Reset (async, active-high): state IDLE, rd_data=0, rd_oe=0, ready=0, err=0, wait register=RESET_WAIT, address latch=0, counter=0. Array contents are not reset.
- Wait register:
  - loads cfg_wait on cfg_wait_ld in any state;
  - the value in use is snapshotted into wait_q when entering WAIT.
- FSM states: IDLE, ADDR, WAIT, RDY, HOLD.
- IDLE:
  - ae=1 → latch addr=bus_ad, go ADDR.
  - Strobe without prior ae → stay IDLE; err only if both strobes high.
- ADDR:
  - ae=1 again → relatch address, stay ADDR.
  - ext_read^ext_write and hit (addr[15:ADDR_W]==BASE) → WAIT, cnt=0. If read, issue array read of addr[ADDR_W-1:0].
  - Strobe and miss → IDLE; no ready ever, the master times out.
  - Both strobes high → err=1, IDLE.
- WAIT:
  - rd_oe=1 for a read.
  - Each edge: if cnt==wait_q → RDY, else cnt+=1.
  - Strobe dropped → abort to IDLE, no write, rd_oe=0.
- Array write: on the edge entering RDY, a write commits bus_ad[7:0] sampled at that edge to array[addr].
- RDY:
  - ready=1 for exactly this cycle.
  - For a read, rd_data holds array[addr] (valid from the second WAIT cycle onward) and rd_oe=1.
  - Next state HOLD.
- HOLD:
  - ready=0; rd_oe stays 1 while ext_read stays high.
  - Both strobes low → IDLE, rd_oe=0, rd_data retained.
  - ae=1 with strobes low → latch address, go ADDR.
- Latency: ready rises wait_q+1 cycles after the edge that first samples the strobe in ADDR. wait_q=0 gives 1 cycle; 255 gives 256 cycles.
- Counter is 8 bit and never wraps, because the compare exits at wait_q ≤ 255.
- err: sticky; err_clr clears it. Simultaneous set and clear → set wins.
- Reset mid-transfer: immediate return to IDLE with all outputs low; any pending write is lost.
- Read-after-write to the same address in the next transaction returns the new data.

Decomposition:
- Shared package ext_bus_pkg holds:
  - state enum (IDLE/ADDR/WAIT/RDY/HOLD);
  - bus widths (AD_W=16, DATA_W=8);
  - default BASE and RESET_WAIT constants, shared with the master-side bus model.
- One sub-module, ext_bus_resp_mem: single-port synchronous byte array (we, addr, din, dout, one-cycle read latency).
- FSM and counter stay in the top module.

Test Plan:
- Write then read, wait=3:
  - Stimulus: ae with bus_ad=16'h0412, then ext_write with data 8'hA5 until ready; then ae 16'h0412 and ext_read.
  - Required: ready pulses 4 cycles after each strobe sample; rd_data=8'hA5 at ready; rd_oe high WAIT..HOLD.
- Wait programming:
  - Stimulus: cfg_wait_ld with 0, read, then cfg_wait_ld with 255, read.
  - Required: ready at 1 cycle, then 256 cycles; ready is exactly one cycle wide in both cases.
- Window miss:
  - Stimulus: ae with 16'h0812 (bits[15:10]=2, BASE=1), then ext_read held for 300 cycles.
  - Required: ready never asserts, rd_oe stays 0, FSM returns to IDLE.
- Abort:
  - Stimulus: write of 8'h3C to 16'h0400 with wait=5; drop ext_write after 2 cycles; then read 16'h0400.
  - Required: read returns the old contents, not 8'h3C; no ready during the aborted write.
- Protocol error:
  - Stimulus: ae, then ext_read and ext_write high together.
  - Required: err=1, no ready, IDLE. Then err_clr asserted in the same cycle as a second error → err stays 1; err_clr alone → err=0.
- Reset mid-WAIT:
  - Stimulus: rst pulse during a read with wait=10.
  - Required: ready, rd_oe, rd_data and err are all 0 immediately; wait register returns to 3; the next transaction completes normally.
